// File: rtl/rf_pkg.sv
// rf_pkg: shared constants, sequencer states and physical-size helper for reg_file_banked.
package rf_pkg;
    localparam int MODE_USR = 0;
    localparam int MODE_IRQ = 1;
    localparam int MODE_SVC = 2;
    localparam int REG_SP = 13;
    localparam int REG_LR = 14;
    localparam int REG_PC = 15;
    typedef enum logic {ST_CLEAR, ST_READY} rf_state_e;
    function automatic int rf_phys_count(input int nbank);
        return 15 + 2 * (nbank - 1);
    endfunction
endpackage

// File: rtl/rf_bank_map.sv
// rf_bank_map: maps (architectural address, mode) to a physical entry index and flags R15.
module rf_bank_map import rf_pkg::*; #(
    parameter int AW = 4,
    parameter int NBANK = 3,
    parameter int PW = 5,
    parameter int MW = 2
) (
    input  logic [AW-1:0] addr,
    input  logic [MW-1:0] mode,
    output logic [PW-1:0] phys,
    output logic          is_pc
);
    logic banked;
    // Banked SP/LR live after R0..R14, two entries per privileged mode.
    always_comb begin
        is_pc = int'(addr) == REG_PC;
        banked = (int'(addr) == REG_SP || int'(addr) == REG_LR) && int'(mode) != MODE_USR && int'(mode) < NBANK;
        phys = banked ? PW'(REG_PC + 2 * (int'(mode) - 1) + int'(addr) - REG_SP) : PW'(addr);
    end
endmodule

// File: rtl/reg_file_banked.sv
// reg_file_banked: multi-port ARM32 register file with banked R13/R14, R15 redirect and a post-reset clear.
// Optional write-first bypass of same-cycle writes when RF_BYPASS_EN is defined.
module reg_file_banked import rf_pkg::*; #(
    parameter int XLEN = 32,
    parameter int AW = 4,
    parameter int NRD = 3,
    parameter int NWR = 2,
    parameter int NBANK = 3,
    parameter int PC_OFS = 8,
    localparam int MW = NBANK > 1 ? $clog2(NBANK) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [MW-1:0]       rf_mode,
    input  logic [NRD*AW-1:0]   rf_rs,
    output logic [NRD*XLEN-1:0] rf_rd,
    input  logic [NWR-1:0]      rf_we,
    input  logic [NWR*AW-1:0]   rf_ws,
    input  logic [NWR*XLEN-1:0] rf_wd,
    input  logic [XLEN-1:0]     pc,
    output logic                rf_pc_we,
    output logic [XLEN-1:0]     rf_pc_wd,
    output logic                rf_busy
);
    localparam int N = rf_phys_count(NBANK);
    localparam int PW = $clog2(N);

    logic [XLEN-1:0]     regs_q [N];
    logic [XLEN-1:0]     regs_d [N];
    logic [NRD*XLEN-1:0] rd_q, rd_d;
    rf_state_e           state_q, state_d;
    logic [PW-1:0]       cnt_q, cnt_d;
    logic                pc_we_q, pc_we_d;
    logic [XLEN-1:0]     pc_wd_q, pc_wd_d;
    logic [PW-1:0]       r_phys [NRD];
    logic [PW-1:0]       w_phys [NWR];
    logic [NRD-1:0]      r_pc;
    logic [NWR-1:0]      w_pc;

    for (genvar i = 0; i < NRD; i++) begin : g_rmap
        rf_bank_map #(.AW(AW), .NBANK(NBANK), .PW(PW), .MW(MW)) u_map (
            .addr(rf_rs[i*AW +: AW]), .mode(rf_mode), .phys(r_phys[i]), .is_pc(r_pc[i])
        );
    end
    for (genvar i = 0; i < NWR; i++) begin : g_wmap
        rf_bank_map #(.AW(AW), .NBANK(NBANK), .PW(PW), .MW(MW)) u_map (
            .addr(rf_ws[i*AW +: AW]), .mode(rf_mode), .phys(w_phys[i]), .is_pc(w_pc[i])
        );
    end

    // Later write ports overwrite earlier ones, giving port NWR-1 priority.
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        regs_d = regs_q;
        pc_we_d = 1'b0;
        pc_wd_d = pc_wd_q;
        if (state_q == ST_CLEAR) begin
            regs_d[cnt_q] = '0;
            cnt_d = cnt_q == PW'(N - 1) ? cnt_q : cnt_q + 1'b1;
            state_d = cnt_q == PW'(N - 1) ? ST_READY : ST_CLEAR;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (rf_we[p] && w_pc[p]) begin
                    pc_we_d = 1'b1;
                    pc_wd_d = rf_wd[p*XLEN +: XLEN];
                end else if (rf_we[p]) begin
                    regs_d[w_phys[p]] = rf_wd[p*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        rd_d = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_d[i*XLEN +: XLEN] = r_pc[i] ? pc + XLEN'(PC_OFS) : regs_q[r_phys[i]];
`ifdef RF_BYPASS_EN
            for (int p = 0; p < NWR; p++) begin
                if (!r_pc[i] && rf_we[p] && !w_pc[p] && w_phys[p] == r_phys[i])
                    rd_d[i*XLEN +: XLEN] = rf_wd[p*XLEN +: XLEN];
            end
`endif
            if (state_q == ST_CLEAR)
                rd_d[i*XLEN +: XLEN] = '0;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
        if (reset) begin
            state_q <= ST_CLEAR;
            cnt_q <= '0;
            rd_q <= '0;
            pc_we_q <= 1'b0;
            pc_wd_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            rd_q <= rd_d;
            pc_we_q <= pc_we_d;
            pc_wd_q <= pc_wd_d;
        end
    end

    assign rf_rd = rd_q;
    assign rf_pc_we = pc_we_q;
    assign rf_pc_wd = pc_wd_q;
    assign rf_busy = state_q == ST_CLEAR;
endmodule

// File: tb/tb_reg_file_banked.sv
// tb_reg_file_banked: directed checks of reg_file_banked at default parameters, with or without RF_BYPASS_EN.
module tb_reg_file_banked;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rf_mode;
    logic [11:0] rf_rs;
    logic [95:0] rf_rd;
    logic [1:0]  rf_we;
    logic [7:0]  rf_ws;
    logic [63:0] rf_wd;
    logic [31:0] pc;
    logic        rf_pc_we;
    logic [31:0] rf_pc_wd;
    logic        rf_busy;
    int          total = 0;
    int          bad = 0;
    int          cyc;
    int          pc_seen;

    reg_file_banked dut (
        .clk(clk), .reset(reset), .rf_mode(rf_mode), .rf_rs(rf_rs), .rf_rd(rf_rd),
        .rf_we(rf_we), .rf_ws(rf_ws), .rf_wd(rf_wd), .pc(pc),
        .rf_pc_we(rf_pc_we), .rf_pc_wd(rf_pc_wd), .rf_busy(rf_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rd(input int i);
        return rf_rd[i*32 +: 32];
    endfunction

    task automatic wait_ready(input string tag);
        cyc = 0;
        pc_seen = 0;
        while (rf_busy && cyc < 40) begin
            tick();
            cyc++;
            if (rf_pc_we) pc_seen++;
        end
        chk(tag, cyc, 19);
        chk({tag, "_pcwe"}, pc_seen, 0);
    endtask

    initial begin
        reset = 1'b1;
        rf_mode = 2'd0;
        rf_rs = '0;
        rf_we = '0;
        rf_ws = '0;
        rf_wd = '0;
        pc = 32'h80;
        tick();
        tick();
        chk("rst_rd0", rd(0), 0);
        chk("rst_pcwe", rf_pc_we, 0);
        chk("rst_pcwd", rf_pc_wd, 0);
        chk("rst_busy", rf_busy, 1);
        reset = 1'b0;
        wait_ready("busy_len");
        for (int m = 0; m < 3; m++) begin
            for (int a = 0; a < 15; a += 3) begin
                rf_mode = 2'(m);
                rf_rs = {4'(a + 2), 4'(a + 1), 4'(a)};
                tick();
                for (int i = 0; i < 3; i++) chk("clr_rd", rd(i), 0);
            end
        end
        rf_mode = 2'd0;
        rf_we = 2'b01; rf_ws = {4'd0, 4'd3}; rf_wd = {32'h0, 32'hDEADBEEF};
        tick();
        rf_we = 2'b00; rf_rs = {4'd0, 4'd0, 4'd3};
        tick();
        chk("r3", rd(0), 32'hDEADBEEF);
        rf_we = 2'b01; rf_ws = {4'd0, 4'd13}; rf_wd = {32'h0, 32'h1000};
        tick();
        rf_mode = 2'd1;
        rf_we = 2'b11; rf_ws = {4'd13, 4'd4}; rf_wd = {32'h2000, 32'h44};
        tick();
        rf_we = 2'b00;
        rf_rs = {4'd4, 4'd14, 4'd13};
        for (int m = 0; m < 3; m++) begin
            rf_mode = 2'(m);
            tick();
            chk("sp_bank", rd(0), m == 0 ? 32'h1000 : m == 1 ? 32'h2000 : 32'h0);
            chk("lr_bank", rd(1), 0);
            chk("r4_shared", rd(2), 32'h44);
        end
        rf_mode = 2'd0;
        rf_rs = {4'd0, 4'd0, 4'd15};
        tick();
        chk("r15_rd", rd(0), 32'h88);
        chk("pcwe_idle", rf_pc_we, 0);
        rf_we = 2'b01; rf_ws = {4'd0, 4'd15}; rf_wd = {32'h0, 32'h200};
        tick();
        rf_we = 2'b00;
        chk("pcwe_pulse", rf_pc_we, 1);
        chk("pcwd", rf_pc_wd, 32'h200);
        pc = 32'h100;
        tick();
        chk("pcwe_single", rf_pc_we, 0);
        chk("r15_track", rd(0), 32'h108);
        rf_mode = 2'd1;
        rf_rs = {4'd0, 4'd0, 4'd13};
        tick();
        chk("r15w_no_store", rd(0), 32'h2000);
        rf_mode = 2'd0;
        rf_we = 2'b11; rf_ws = {4'd15, 4'd15}; rf_wd = {32'h400, 32'h300};
        tick();
        rf_we = 2'b00;
        chk("pc_both_we", rf_pc_we, 1);
        chk("pc_both_wd", rf_pc_wd, 32'h400);
        rf_we = 2'b01; rf_ws = {4'd0, 4'd5}; rf_wd = {32'h0, 32'h77};
        tick();
        rf_we = 2'b11; rf_ws = {4'd5, 4'd5}; rf_wd = {32'h22, 32'h11};
        rf_rs = {4'd0, 4'd0, 4'd5};
        tick();
        rf_we = 2'b00;
`ifdef RF_BYPASS_EN
        chk("r5_same_cycle", rd(0), 32'h22);
`else
        chk("r5_same_cycle", rd(0), 32'h77);
`endif
        tick();
        chk("r5_prio", rd(0), 32'h22);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_busy", rf_busy, 1);
        rf_rs = {4'd0, 4'd0, 4'd3};
        rf_we = 2'b11; rf_ws = {4'd15, 4'd3}; rf_wd = {32'h500, 32'h99};
        tick();
        tick();
        chk("clear_rd0", rd(0), 0);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_ready("busy_len2");
        rf_we = 2'b00;
        rf_rs = {4'd13, 4'd5, 4'd3};
        tick();
        chk("r3_cleared", rd(0), 0);
        chk("r5_cleared", rd(1), 0);
        chk("r13_cleared", rd(2), 0);
        rf_mode = 2'd1;
        tick();
        chk("irq_r13_cleared", rd(2), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
